mem_dump_ctrl: RTL and testbench

//  Front-panel sequencer directly upstream of the pipelined CPU top: generates its memread_en and
//  out_addr inputs. Debounces board buttons, halts the CPU through memread_en (Hazard stalls on it),

---
 rtl/cpu_dbg_pkg.sv | 20 ++
 rtl/mem_dump_ctrl_if.sv | 13 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/mem_dump_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_dump_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and default timing constants for the front-panel memory dump sequencer.
// The defaults are sized for the board clock. A simulation instance overrides them with small values.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;
  localparam int unsigned DEF_SCAN_DIV     = 50000000;

  // Width of a counter that must hold the values 0 .. n-1. The result is never below 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_ctrl_if.sv
// Dump-side control bundle presented to the CPU top and the display logic.
// The master drives it and the CPU/display side observes it.
interface mem_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              memread_en;
  logic [ADDR_W-1:0] out_addr;
  logic              data_valid;
  logic              dump_mode;

  modport master (output memread_en, output out_addr, output data_valid, output dump_mode);
  modport slave  (input  memread_en, input  out_addr, input  data_valid, input  dump_mode);
endinterface

// File: rtl/btn_debounce.sv
// Raw button to single-cycle press pulse: a 2-FF synchroniser, a stability counter and a rising-edge pulse.
// A level is accepted only after DEBOUNCE_CYC consecutive samples that differ from the current accepted level.
module btn_debounce
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments let the synchroniser stages shift by one per clock instead of collapsing into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Front-panel dump sequencer: it stalls the CPU, waits for stores to drain and then steps a word address.
// Data memory port B can then be shown on the display. Every output comes directly from a register.
module mem_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned DRAIN_CYC    = 4,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_dump,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  mem_dump_ctrl_if.master  bus
);

  localparam int unsigned PH_MAX = (DRAIN_CYC > READ_LAT) ? DRAIN_CYC : READ_LAT;
  localparam int unsigned PH_W   = cnt_width(PH_MAX);
  localparam int unsigned SC_W   = cnt_width(SCAN_DIV);

  logic p_dump, p_next, p_prev;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dump (.clk(clk), .rst(rst), .btn(btn_dump), .pulse(p_dump));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (.clk(clk), .rst(rst), .btn(btn_next), .pulse(p_next));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (.clk(clk), .rst(rst), .btn(btn_prev), .pulse(p_prev));

  state_t          state;
  logic [PH_W-1:0] phase_cnt;
  logic [SC_W-1:0] scan_cnt;
  logic [1:0]      auto_sync;
  logic            auto_d;
  logic            auto_on;
  logic            auto_rise;

  // auto_en is a slow switch, so it is synchronised but not debounced.
  assign auto_on   = auto_sync[1];
  assign auto_rise = auto_sync[1] & ~auto_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      phase_cnt      <= '0;
      scan_cnt       <= '0;
      auto_sync      <= 2'b00;
      auto_d         <= 1'b0;
      bus.memread_en <= 1'b0;
      bus.out_addr   <= '0;
      bus.data_valid <= 1'b0;
      bus.dump_mode  <= 1'b0;
    end else begin
      auto_sync <= {auto_sync[0], auto_en};
      auto_d    <= auto_sync[1];

      unique case (state)
        RUN: begin
          if (p_dump) begin
            state          <= DRAIN;
            phase_cnt      <= '0;
            bus.memread_en <= 1'b1;
            bus.dump_mode  <= 1'b1;
          end
        end

        DRAIN: begin
          if (p_dump) begin
            state          <= RUN;
            bus.memread_en <= 1'b0;
            bus.dump_mode  <= 1'b0;
          end else if (phase_cnt == PH_W'(DRAIN_CYC - 1)) begin
            state     <= WAIT;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        WAIT: begin
          if (p_dump) begin
            state          <= RUN;
            bus.memread_en <= 1'b0;
            bus.dump_mode  <= 1'b0;
          end else if (phase_cnt == PH_W'(READ_LAT - 1)) begin
            state          <= SHOW;
            scan_cnt       <= '0;
            bus.data_valid <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        SHOW: begin
          // A dump pulse wins over any address step that arrives in the same cycle.
          if (p_dump) begin
            state          <= RUN;
            bus.memread_en <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.dump_mode  <= 1'b0;
          end else if (auto_on) begin
            if (auto_rise) begin
              scan_cnt <= '0;
            end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
              state          <= WAIT;
              phase_cnt      <= '0;
              bus.data_valid <= 1'b0;
              bus.out_addr   <= bus.out_addr + 1'b1;
            end else begin
              scan_cnt <= scan_cnt + 1'b1;
            end
          end else if (p_next ^ p_prev) begin
            state          <= WAIT;
            phase_cnt      <= '0;
            bus.data_valid <= 1'b0;
            bus.out_addr   <= p_next ? bus.out_addr + 1'b1 : bus.out_addr - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl. It drives directed and randomised button sequences.
// Each result is compared with an address model and a dump-port memory that the bench owns.
module tb_mem_dump_ctrl;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned DRAIN_CYC    = 16;
  localparam int unsigned READ_LAT     = 1;
  localparam int unsigned SCAN_DIV     = 8;
  localparam int          HOLD         = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_dump = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, auto_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] model_addr;
  logic [31:0]       mem [256];
  logic [31:0]       doutb;

  always #5 clk = ~clk;

  mem_dump_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_dump_ctrl #(
    .ADDR_W(ADDR_W), .DEBOUNCE_CYC(DEBOUNCE_CYC), .DRAIN_CYC(DRAIN_CYC),
    .READ_LAT(READ_LAT), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .btn_dump(btn_dump), .btn_next(btn_next),
    .btn_prev(btn_prev), .auto_en(auto_en), .bus(bus)
  );

  // Memory port B with a one-cycle read latency.
  always @(posedge clk) doutb <= mem[bus.out_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_btns(input int which, input logic v);
    case (which)
      0:       btn_dump = v;
      1:       btn_next = v;
      2:       btn_prev = v;
      default: begin btn_next = v; btn_prev = v; end
    endcase
  endtask

  task automatic bounce(input int which);
    set_btns(which, 1'b1); @(negedge clk);
    set_btns(which, 1'b0); @(negedge clk);
  endtask

  task automatic wait_mre(input string tag, input logic val);
    int n = 0;
    while (bus.memread_en !== val && n < 30) begin @(negedge clk); n++; end
    check(tag, bus.memread_en, val);
  endtask

  // Each step must move the address by exactly one. Valid must then drop for READ_LAT cycles.
  task automatic step(input int which, input bit bnc);
    logic [ADDR_W-1:0] exp_addr;
    int n = 0;
    int low = 0;
    exp_addr = (which == 1) ? model_addr + 8'd1 : model_addr - 8'd1;
    if (bnc) bounce(which);
    set_btns(which, 1'b1);
    while (bus.out_addr === model_addr && n < 25) begin @(negedge clk); n++; end
    check("step_addr", bus.out_addr, exp_addr);
    while (bus.data_valid !== 1'b1 && low < 10) begin low++; @(negedge clk); end
    check("step_valid_gap", low, READ_LAT);
    check("step_data", doutb, mem[exp_addr]);
    model_addr = exp_addr;
    set_btns(which, 1'b0);
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic enter_dump(input bit bnc);
    int n = 0;
    if (bnc) bounce(0);
    set_btns(0, 1'b1);
    wait_mre("enter_mre", 1'b1);
    check("enter_led", bus.dump_mode, 1'b1);
    while (bus.data_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("enter_latency", n, DRAIN_CYC + READ_LAT);
    check("enter_addr", bus.out_addr, model_addr);
    check("enter_data", doutb, mem[model_addr]);
    repeat (HOLD) @(negedge clk);
    set_btns(0, 1'b0);
    repeat (HOLD) @(negedge clk);
    check("enter_no_repeat", {bus.memread_en, bus.data_valid}, 2'b11);
  endtask

  task automatic exit_dump();
    set_btns(0, 1'b1);
    wait_mre("exit_mre", 1'b0);
    check("exit_valid", bus.data_valid, 1'b0);
    check("exit_led", bus.dump_mode, 1'b0);
    check("exit_addr", bus.out_addr, model_addr);
    set_btns(0, 1'b0);
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic goto_addr(input logic [ADDR_W-1:0] target);
    while (model_addr != target) step((target - model_addr) < 8'd128 ? 1 : 2, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv_drops;
    int changes;
    int last_t;
    bit seen_valid;
    logic [31:0] fresh;

    model_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mre", bus.memread_en, 1'b0);
    check("rst_addr", bus.out_addr, 8'h00);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_led", bus.dump_mode, 1'b0);

    // A store to address 0 while the CPU still runs must be visible once the dump starts.
    repeat (5) @(negedge clk);
    mem[0] = $urandom;
    enter_dump(1'b1);

    // Wrap below zero and above the maximum address.
    step(2, 1'b0);
    step(1, 1'b1);
    step(2, 1'b0);
    step(1, 1'b0);

    // Pressing next and prev together must leave the address alone.
    dv_drops = 0;
    set_btns(3, 1'b1);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.data_valid !== 1'b1 || bus.out_addr !== model_addr) dv_drops++;
    end
    set_btns(3, 1'b0);
    repeat (HOLD) @(negedge clk);
    check("both_disturb", dv_drops, 0);
    check("both_addr", bus.out_addr, model_addr);

    for (int k = 0; k < int'($urandom_range(12, 6)); k++)
      step(int'($urandom_range(2, 1)), 1'($urandom_range(1, 0)));

    // Auto-scan from address 0. The next-button press made during the scan must be ignored.
    goto_addr(8'h00);
    changes = 0;
    last_t  = 0;
    auto_en = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c == 15) btn_next = 1'b1;
      if (c == 25) btn_next = 1'b0;
      if (c == 50) auto_en = 1'b0;
      @(negedge clk);
      if (bus.out_addr !== model_addr) begin
        check("auto_addr", bus.out_addr, model_addr + 8'd1);
        if (changes > 0) check("auto_spacing", c - last_t, SCAN_DIV + READ_LAT);
        model_addr = model_addr + 8'd1;
        last_t = c;
        changes++;
      end
    end
    check("auto_steps", changes >= 4, 1'b1);
    check("auto_stopped", bus.out_addr, model_addr);

    exit_dump();

    // A new store goes in, and then a dump request is aborted while the CPU drains.
    fresh = $urandom;
    mem[model_addr] = fresh;
    seen_valid = 1'b0;
    set_btns(0, 1'b1);
    wait_mre("abort_enter", 1'b1);
    set_btns(0, 1'b0);
    repeat (6) begin @(negedge clk); if (bus.data_valid) seen_valid = 1'b1; end
    set_btns(0, 1'b1);
    for (int n = 0; n < 20 && bus.memread_en === 1'b1; n++) begin
      @(negedge clk);
      if (bus.data_valid) seen_valid = 1'b1;
    end
    check("abort_mre", bus.memread_en, 1'b0);
    check("abort_no_show", seen_valid, 1'b0);
    check("abort_led", bus.dump_mode, 1'b0);
    check("abort_addr", bus.out_addr, model_addr);
    set_btns(0, 1'b0);
    repeat (HOLD) @(negedge clk);

    enter_dump(1'b0);
    check("store_readback", doutb, fresh);

    // Reset while the dump is showing address 5.
    goto_addr(8'h05);
    check("pre_rst_addr", bus.out_addr, 8'h05);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mre", bus.memread_en, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("show_rst_mre", bus.memread_en, 1'b0);
    check("show_rst_addr", bus.out_addr, 8'h00);
    check("show_rst_valid", bus.data_valid, 1'b0);
    check("show_rst_led", bus.dump_mode, 1'b0);
    repeat (10) @(negedge clk);
    check("post_rst_idle", {bus.memread_en, bus.dump_mode}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
